// File: rtl/wb_bus_arbiter.sv
// Round-robin Wishbone bus arbiter. A grant is held until the owner drops CYC; a watchdog revokes
// a grant held for TIMEOUT_CYCLES cycles and blocks that master until it drops CYC once.
module wb_bus_arbiter #(
  parameter int unsigned N_MASTERS      = 2,
  parameter int unsigned N_BITS_MASTER  = 1,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned N_BITS_TIMEOUT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_MASTERS-1:0]     cyc_i,
  output logic [N_MASTERS-1:0]     gnt_o,
  output logic [N_BITS_MASTER-1:0] gnt_id_o,
  output logic                     bus_busy_o,
  output logic                     timeout_o,
  output logic [N_BITS_MASTER-1:0] timeout_id_o
);

  localparam bit WdogEn = (TIMEOUT_CYCLES != 0);
  localparam logic [N_BITS_TIMEOUT-1:0] TimeoutLast =
      WdogEn ? N_BITS_TIMEOUT'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [N_BITS_TIMEOUT-1:0] CntMax = {N_BITS_TIMEOUT{1'b1}};
  localparam logic [N_BITS_MASTER-1:0] LastIdRst = N_BITS_MASTER'(N_MASTERS - 1);
  localparam logic [N_MASTERS-1:0] OneHot0 = {{(N_MASTERS - 1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StGrant, StRelease} state_e;

  state_e                    state_q, state_d;
  logic [N_MASTERS-1:0]      gnt_q, gnt_d;
  logic [N_BITS_MASTER-1:0]  gnt_id_q, gnt_id_d;
  logic [N_BITS_MASTER-1:0]  last_id_q, last_id_d;
  logic [N_BITS_TIMEOUT-1:0] cnt_q, cnt_d;
  logic [N_MASTERS-1:0]      blocked_q, blocked_d;
  logic                      timeout_q, timeout_d;
  logic [N_BITS_MASTER-1:0]  timeout_id_q, timeout_id_d;

  logic [N_MASTERS-1:0]      eligible;
  logic                      any_elig;
  logic [N_BITS_MASTER-1:0]  winner;
  logic                      hi_found, lo_found;
  logic [N_BITS_MASTER-1:0]  hi_idx, lo_idx;
  logic                      owner_cyc;

  assign eligible  = cyc_i & ~blocked_q;
  assign owner_cyc = |(cyc_i & gnt_q);

  // Rotating priority: lowest eligible index above last_id wins, else wrap to lowest at/below it.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = N_MASTERS - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        if (i > int'(last_id_q)) begin
          hi_found = 1'b1;
          hi_idx   = N_BITS_MASTER'(i);
        end else begin
          lo_found = 1'b1;
          lo_idx   = N_BITS_MASTER'(i);
        end
      end
    end
    any_elig = hi_found | lo_found;
    winner   = hi_found ? hi_idx : lo_idx;
  end

  // Next-state logic: arbitrate in idle/turnaround, hold and watch the owner in grant.
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    gnt_id_d     = gnt_id_q;
    last_id_d    = last_id_q;
    cnt_d        = cnt_q;
    timeout_d    = 1'b0;
    timeout_id_d = timeout_id_q;
    // A blocked master becomes eligible again once it has dropped CYC.
    blocked_d    = blocked_q & cyc_i;
    unique case (state_q)
      StIdle, StRelease: begin
        if (any_elig) begin
          state_d   = StGrant;
          gnt_d     = OneHot0 << winner;
          gnt_id_d  = winner;
          last_id_d = winner;
          cnt_d     = '0;
        end else begin
          state_d = StIdle;
        end
      end
      StGrant: begin
        if (!owner_cyc) begin
          // Owner release takes precedence over a coincident watchdog expiry.
          state_d = StRelease;
          gnt_d   = '0;
        end else if (WdogEn && (cnt_q == TimeoutLast)) begin
          state_d      = StRelease;
          gnt_d        = '0;
          timeout_d    = 1'b1;
          timeout_id_d = gnt_id_q;
          blocked_d    = blocked_d | gnt_q;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = '0;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      gnt_q        <= '0;
      gnt_id_q     <= '0;
      last_id_q    <= LastIdRst;
      cnt_q        <= '0;
      blocked_q    <= '0;
      timeout_q    <= 1'b0;
      timeout_id_q <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      gnt_id_q     <= gnt_id_d;
      last_id_q    <= last_id_d;
      cnt_q        <= cnt_d;
      blocked_q    <= blocked_d;
      timeout_q    <= timeout_d;
      timeout_id_q <= timeout_id_d;
    end
  end

  assign gnt_o        = gnt_q;
  assign gnt_id_o     = gnt_id_q;
  assign bus_busy_o   = |gnt_q;
  assign timeout_o    = timeout_q;
  assign timeout_id_o = timeout_id_q;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Scoreboard bench for wb_bus_arbiter: three instances (default, short watchdog, three masters).
// Each vector gives the inputs for one cycle and the outputs expected right after that edge.
module tb_wb_bus_arbiter;

  typedef struct packed {
    logic [1:0] sel;
    logic [2:0] gnt;
    logic [1:0] gid;
    logic       to;
    logic [1:0] tid;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] cyc_a = '0;
  logic [1:0] cyc_b = '0;
  logic [2:0] cyc_c = '0;

  logic [1:0] gnt_a, gnt_b;
  logic [2:0] gnt_c;
  logic       gid_a, gid_b;
  logic [1:0] gid_c;
  logic       busy_a, busy_b, busy_c;
  logic       to_a, to_b, to_c;
  logic       tid_a, tid_b;
  logic [1:0] tid_c;

  exp_t sb_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  wb_bus_arbiter #(
    .N_MASTERS(2), .N_BITS_MASTER(1), .TIMEOUT_CYCLES(255), .N_BITS_TIMEOUT(8)
  ) u_def (
    .clk(clk), .rst(rst), .cyc_i(cyc_a), .gnt_o(gnt_a), .gnt_id_o(gid_a),
    .bus_busy_o(busy_a), .timeout_o(to_a), .timeout_id_o(tid_a)
  );

  wb_bus_arbiter #(
    .N_MASTERS(2), .N_BITS_MASTER(1), .TIMEOUT_CYCLES(8), .N_BITS_TIMEOUT(4)
  ) u_to (
    .clk(clk), .rst(rst), .cyc_i(cyc_b), .gnt_o(gnt_b), .gnt_id_o(gid_b),
    .bus_busy_o(busy_b), .timeout_o(to_b), .timeout_id_o(tid_b)
  );

  wb_bus_arbiter #(
    .N_MASTERS(3), .N_BITS_MASTER(2), .TIMEOUT_CYCLES(255), .N_BITS_TIMEOUT(8)
  ) u_n3 (
    .clk(clk), .rst(rst), .cyc_i(cyc_c), .gnt_o(gnt_c), .gnt_id_o(gid_c),
    .bus_busy_o(busy_c), .timeout_o(to_c), .timeout_id_o(tid_c)
  );

  // Drive one cycle of stimulus on the selected instance and queue its expected response.
  task automatic apply(input int sel, input logic r, input logic [2:0] cyc, input logic [2:0] g,
                       input logic [1:0] gid, input logic to, input logic [1:0] tid);
    exp_t e;
    @(negedge clk);
    rst   = r;
    cyc_a = (sel == 0) ? cyc[1:0] : 2'b00;
    cyc_b = (sel == 1) ? cyc[1:0] : 2'b00;
    cyc_c = (sel == 2) ? cyc : 3'b000;
    e.sel = 2'(sel);
    e.gnt = g;
    e.gid = gid;
    e.to  = to;
    e.tid = tid;
    sb_q.push_back(e);
  endtask

  // Monitor: after every rising edge, compare the selected instance against the next expectation.
  initial begin
    exp_t       e;
    logic [2:0] a_gnt;
    logic [1:0] a_gid, a_tid;
    logic       a_busy, a_to;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        case (e.sel)
          2'd0: begin
            a_gnt = {1'b0, gnt_a}; a_gid = {1'b0, gid_a}; a_busy = busy_a;
            a_to = to_a; a_tid = {1'b0, tid_a};
          end
          2'd1: begin
            a_gnt = {1'b0, gnt_b}; a_gid = {1'b0, gid_b}; a_busy = busy_b;
            a_to = to_b; a_tid = {1'b0, tid_b};
          end
          default: begin
            a_gnt = gnt_c; a_gid = gid_c; a_busy = busy_c; a_to = to_c; a_tid = tid_c;
          end
        endcase
        if ((a_gnt !== e.gnt) || (a_gid !== e.gid) || (a_busy !== (|e.gnt)) ||
            (a_to !== e.to) || (a_tid !== e.tid)) begin
          n_fail++;
          $display("FAIL vec%0d dut%0d: got gnt=%b id=%0d busy=%b to=%b tid=%0d, need gnt=%b id=%0d busy=%b to=%b tid=%0d",
                   n_vec, e.sel, a_gnt, a_gid, a_busy, a_to, a_tid,
                   e.gnt, e.gid, |e.gnt, e.to, e.tid);
        end
        n_vec++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, %0d vectors checked", n_vec);
    $fatal(1, "global timeout");
  end

  initial begin
    // Reset with both requesting, then master 0 wins first; round robin after a re-request.
    apply(0, 1, 3'b011, 3'b000, 0, 0, 0);
    apply(0, 1, 3'b011, 3'b000, 0, 0, 0);
    apply(0, 0, 3'b011, 3'b001, 0, 0, 0);
    repeat (3) apply(0, 0, 3'b011, 3'b001, 0, 0, 0);
    apply(0, 0, 3'b010, 3'b000, 0, 0, 0);
    apply(0, 0, 3'b011, 3'b010, 1, 0, 0);
    repeat (2) apply(0, 0, 3'b011, 3'b010, 1, 0, 0);
    apply(0, 0, 3'b001, 3'b000, 1, 0, 0);
    apply(0, 0, 3'b001, 3'b001, 0, 0, 0);
    apply(0, 0, 3'b000, 3'b000, 0, 0, 0);
    apply(0, 0, 3'b000, 3'b000, 0, 0, 0);
    // Single master: five request cycles give five grant cycles, then idle.
    apply(0, 1, 3'b000, 3'b000, 0, 0, 0);
    repeat (5) apply(0, 0, 3'b001, 3'b001, 0, 0, 0);
    apply(0, 0, 3'b000, 3'b000, 0, 0, 0);
    // Reset mid-grant to master 1, then master 0 has priority again.
    apply(0, 1, 3'b000, 3'b000, 0, 0, 0);
    apply(0, 0, 3'b010, 3'b010, 1, 0, 0);
    apply(0, 0, 3'b010, 3'b010, 1, 0, 0);
    apply(0, 1, 3'b011, 3'b000, 0, 0, 0);
    apply(0, 0, 3'b011, 3'b001, 0, 0, 0);
    apply(0, 0, 3'b000, 3'b000, 0, 0, 0);

    // Watchdog of 8 cycles: master 0 revoked, master 1 served, master 0 blocked until it drops.
    apply(1, 1, 3'b000, 3'b000, 0, 0, 0);
    repeat (8) apply(1, 0, 3'b011, 3'b001, 0, 0, 0);
    apply(1, 0, 3'b011, 3'b000, 0, 1, 0);
    apply(1, 0, 3'b011, 3'b010, 1, 0, 0);
    apply(1, 0, 3'b011, 3'b010, 1, 0, 0);
    apply(1, 0, 3'b001, 3'b000, 1, 0, 0);
    apply(1, 0, 3'b001, 3'b000, 1, 0, 0);
    apply(1, 0, 3'b001, 3'b000, 1, 0, 0);
    apply(1, 0, 3'b000, 3'b000, 1, 0, 0);
    apply(1, 0, 3'b001, 3'b001, 0, 0, 0);
    apply(1, 0, 3'b000, 3'b000, 0, 0, 0);
    // Master 1 times out: timeout_id becomes 1 and holds.
    repeat (8) apply(1, 0, 3'b010, 3'b010, 1, 0, 0);
    apply(1, 0, 3'b010, 3'b000, 1, 1, 1);
    apply(1, 0, 3'b010, 3'b000, 1, 0, 1);
    apply(1, 0, 3'b000, 3'b000, 1, 0, 1);
    // Owner drops CYC in the expiry cycle: plain release, no pulse, no block.
    repeat (8) apply(1, 0, 3'b001, 3'b001, 0, 0, 1);
    apply(1, 0, 3'b000, 3'b000, 0, 0, 1);
    apply(1, 0, 3'b001, 3'b001, 0, 0, 1);
    apply(1, 0, 3'b000, 3'b000, 0, 0, 1);

    // Three masters: order 0,1,2,0 with one idle cycle between owners, then wrap cases.
    apply(2, 1, 3'b000, 3'b000, 0, 0, 0);
    apply(2, 0, 3'b111, 3'b001, 0, 0, 0);
    apply(2, 0, 3'b111, 3'b001, 0, 0, 0);
    apply(2, 0, 3'b110, 3'b000, 0, 0, 0);
    apply(2, 0, 3'b111, 3'b010, 1, 0, 0);
    apply(2, 0, 3'b111, 3'b010, 1, 0, 0);
    apply(2, 0, 3'b101, 3'b000, 1, 0, 0);
    apply(2, 0, 3'b111, 3'b100, 2, 0, 0);
    apply(2, 0, 3'b111, 3'b100, 2, 0, 0);
    apply(2, 0, 3'b011, 3'b000, 2, 0, 0);
    apply(2, 0, 3'b111, 3'b001, 0, 0, 0);
    apply(2, 0, 3'b000, 3'b000, 0, 0, 0);
    apply(2, 0, 3'b100, 3'b100, 2, 0, 0);
    apply(2, 0, 3'b000, 3'b000, 2, 0, 0);
    apply(2, 0, 3'b010, 3'b010, 1, 0, 0);
    apply(2, 0, 3'b000, 3'b000, 1, 0, 0);
    apply(2, 0, 3'b001, 3'b001, 0, 0, 0);
    apply(2, 0, 3'b000, 3'b000, 0, 0, 0);

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
    #2;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, need 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
